// File: rtl/uart_core_param.sv
// Parametrised single-clock UART: TX/RX serialisers, each with a synchronous FIFO.
// Bit timing comes from per-direction dividers counting pclk_i cycles.

module uart_core_param #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_WIDTH   = 4
) (
    input  logic                 pclk_i,
    input  logic                 master_reset,
    input  logic [DATA_BITS-1:0] tx_pdata_i,
    input  logic                 tx_pdata_valid_i,
    output logic                 tx_pready_o,
    output logic                 tx_sdata_o,
    output logic                 tx_busy_o,
    input  logic                 rx_sdata_i,
    input  logic                 read_ready_i,
    output logic [DATA_BITS-1:0] rx_pdata_o,
    output logic                 rx_pdata_valid_o,
    output logic                 rx_pdata_err_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_overflow_o
);

    localparam int PTR_W   = ADDR_WIDTH + 1;
    localparam int CNT_W   = $clog2(2 * CLKS_PER_BIT);
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam int ENTRY_W = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             HAS_PAR   = (PARITY != 0);
    localparam logic             PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PTR_W-1:0]     tx_rd_ptr_q, tx_rd_ptr_d;
    logic                 tx_pready_q;
    logic                 tx_full_d;
    logic                 tx_empty;
    logic                 tx_push;
    logic                 tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_push  = tx_pdata_valid_i && tx_pready_q;
    assign tx_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign tx_head  = tx_mem_q[tx_rd_ptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(tx_pop);
        tx_full_d   = (tx_wr_ptr_d[ADDR_WIDTH] != tx_rd_ptr_d[ADDR_WIDTH]) &&
                      (tx_wr_ptr_d[ADDR_WIDTH-1:0] == tx_rd_ptr_d[ADDR_WIDTH-1:0]);
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge pclk_i) begin
        if (master_reset) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_pready_q <= 1'b1;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_pready_q <= !tx_full_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; empty pointers make its contents invisible.
    always_ff @(posedge pclk_i) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q[ADDR_WIDTH-1:0]] <= tx_pdata_i;
        end
    end

    // ------------------------------------------------------------------
    // TX serialiser; the line is registered one cycle behind the state.
    // ------------------------------------------------------------------
    state_t               tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_sdata_q, tx_sdata_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_idx_d   = tx_idx_q;
        tx_shreg_d = tx_shreg_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;

        unique case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shreg_d = tx_head;
                    tx_par_d   = (^tx_head) ^ PAR_ODD;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shreg_d = tx_shreg_q >> 1;
                    if (tx_idx_q == IDX_LAST) begin
                        tx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == STOP_LAST) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shreg_d = tx_head;
                        tx_par_d   = (^tx_head) ^ PAR_ODD;
                        tx_state_d = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        unique case (tx_state_q)
            ST_START:  tx_sdata_d = 1'b0;
            ST_DATA:   tx_sdata_d = tx_shreg_q[0];
            ST_PARITY: tx_sdata_d = tx_par_q;
            default:   tx_sdata_d = 1'b1;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (master_reset) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shreg_q <= '0;
            tx_par_q   <= 1'b0;
            tx_sdata_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shreg_q <= tx_shreg_d;
            tx_par_q   <= tx_par_d;
            tx_sdata_q <= tx_sdata_d;
        end
    end

    assign tx_pready_o = tx_pready_q;
    assign tx_sdata_o  = tx_sdata_q;
    assign tx_busy_o   = (tx_state_q != ST_IDLE) || !tx_empty;

    // ------------------------------------------------------------------
    // RX synchroniser and deserialiser
    // ------------------------------------------------------------------
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    state_t               rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
    logic                 rx_par_bit_q, rx_par_bit_d;
    logic                 rx_perr;
    logic                 rx_wr;
    logic [ENTRY_W-1:0]   rx_wr_data;

    assign rx_perr    = HAS_PAR ? ((^rx_shreg_q) ^ rx_par_bit_q ^ PAR_ODD) : 1'b0;
    assign rx_wr_data = {~rx_sync_q, rx_perr, rx_shreg_q};

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + CNT_W'(1);
        rx_idx_d     = rx_idx_q;
        rx_shreg_d   = rx_shreg_q;
        rx_par_bit_d = rx_par_bit_q;
        rx_wr        = 1'b0;

        unique case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                // Mid-bit check of the start bit rejects short glitches.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shreg_d = {rx_sync_q, rx_shreg_q[DATA_BITS-1:1]};
                    if (rx_idx_q == IDX_LAST) begin
                        rx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d     = '0;
                    rx_par_bit_d = rx_sync_q;
                    rx_state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_wr      = 1'b1;
                    rx_state_d = ST_IDLE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (master_reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= ST_IDLE;
            rx_cnt_q     <= '0;
            rx_idx_q     <= '0;
            rx_shreg_q   <= '0;
            rx_par_bit_q <= 1'b0;
        end else begin
            rx_meta_q    <= rx_sdata_i;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_shreg_q   <= rx_shreg_d;
            rx_par_bit_q <= rx_par_bit_d;
        end
    end

    // ------------------------------------------------------------------
    // RX show-ahead FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] rx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rx_wr_ptr_q, rx_rd_ptr_q;
    logic               rx_overflow_q;
    logic               rx_empty, rx_full, rx_pop, rx_push;
    logic [ENTRY_W-1:0] rx_head;

    assign rx_empty = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_full  = (rx_wr_ptr_q[ADDR_WIDTH] != rx_rd_ptr_q[ADDR_WIDTH]) &&
                      (rx_wr_ptr_q[ADDR_WIDTH-1:0] == rx_rd_ptr_q[ADDR_WIDTH-1:0]);
    assign rx_pop   = !rx_empty && read_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign rx_push  = rx_wr && (!rx_full || rx_pop);
    assign rx_head  = rx_mem_q[rx_rd_ptr_q[ADDR_WIDTH-1:0]];

    always_ff @(posedge pclk_i) begin
        if (master_reset) begin
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            rx_wr_ptr_q   <= rx_wr_ptr_q + PTR_W'(rx_push);
            rx_rd_ptr_q   <= rx_rd_ptr_q + PTR_W'(rx_pop);
            rx_overflow_q <= rx_overflow_q || (rx_wr && !rx_push);
        end
    end

    always_ff @(posedge pclk_i) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q[ADDR_WIDTH-1:0]] <= rx_wr_data;
        end
    end

    // Outputs are masked while empty so unreset storage never leaks out.
    assign rx_pdata_valid_o = !rx_empty;
    assign rx_pdata_o       = rx_empty ? '0 : rx_head[DATA_BITS-1:0];
    assign rx_pdata_err_o   = !rx_empty && rx_head[DATA_BITS];
    assign rx_frame_err_o   = !rx_empty && rx_head[DATA_BITS+1];
    assign rx_overflow_o    = rx_overflow_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param: an even-parity instance (loopback capable)
// and an odd-parity, two-stop-bit instance, with a scoreboard of expected RX entries.

module tb_uart_core_param;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int FRAME = CPB * 11;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic       master_reset;
    logic [7:0] tx_pdata;
    logic       tx_valid, tx_pready, tx_sdata, tx_busy;
    logic       loopback, bench_rx, rx_line;
    logic       read_ready;
    logic [7:0] rx_pdata;
    logic       rx_valid, rx_perr, rx_ferr, rx_ovf;

    logic [7:0] o_tx_pdata;
    logic       o_tx_valid, o_tx_pready, o_tx_sdata, o_tx_busy;
    logic       odd_rx, o_read_ready;
    logic [7:0] o_rx_pdata;
    logic       o_rx_valid, o_rx_perr, o_rx_ferr, o_rx_ovf;

    assign rx_line = loopback ? tx_sdata : bench_rx;

    uart_core_param #(
        .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
        .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(4)
    ) u_dut (
        .pclk_i(pclk), .master_reset(master_reset),
        .tx_pdata_i(tx_pdata), .tx_pdata_valid_i(tx_valid),
        .tx_pready_o(tx_pready), .tx_sdata_o(tx_sdata), .tx_busy_o(tx_busy),
        .rx_sdata_i(rx_line), .read_ready_i(read_ready),
        .rx_pdata_o(rx_pdata), .rx_pdata_valid_o(rx_valid),
        .rx_pdata_err_o(rx_perr), .rx_frame_err_o(rx_ferr), .rx_overflow_o(rx_ovf)
    );

    uart_core_param #(
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
        .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(4)
    ) u_odd (
        .pclk_i(pclk), .master_reset(master_reset),
        .tx_pdata_i(o_tx_pdata), .tx_pdata_valid_i(o_tx_valid),
        .tx_pready_o(o_tx_pready), .tx_sdata_o(o_tx_sdata), .tx_busy_o(o_tx_busy),
        .rx_sdata_i(odd_rx), .read_ready_i(o_read_ready),
        .rx_pdata_o(o_rx_pdata), .rx_pdata_valid_o(o_rx_valid),
        .rx_pdata_err_o(o_rx_perr), .rx_frame_err_o(o_rx_ferr), .rx_overflow_o(o_rx_ovf)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard entries are {frame_err, parity_err, data}.
    logic [9:0] exp_q[$];
    logic [9:0] odd_q[$];

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // Line model: index 0 = start, 1..8 = data LSB first, 9 = even parity, 10 = stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    task automatic set_line(input bit to_odd, input logic b);
        if (to_odd) odd_rx = b;
        else        bench_rx = b;
    endtask

    task automatic drive_frame(input bit to_odd, input logic [7:0] data,
                               input bit flip_par, input logic stop_val);
        logic par;
        par = (to_odd ? ~(^data) : (^data)) ^ flip_par;
        set_line(to_odd, 1'b0);
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            set_line(to_odd, data[i]);
            tick(CPB);
        end
        set_line(to_odd, par);
        tick(CPB);
        set_line(to_odd, stop_val);
        tick(to_odd ? 2 * CPB : CPB);
        set_line(to_odd, 1'b1);
        tick(2 * CPB);
    endtask

    // Waits for the head entry, compares it with the oldest expectation, then pops it.
    task automatic sb_pop_compare(input bit from_odd, input string name);
        int         waited;
        logic [9:0] exp, act;
        waited = 0;
        while (!(from_odd ? o_rx_valid : rx_valid) && waited < 3000) begin
            tick(1);
            waited++;
        end
        checks++;
        if (waited >= 3000) begin
            errors++;
            $display("FAIL %s: rx_pdata_valid_o stayed 0 for %0d cycles, expected 1", name, waited);
            return;
        end
        if ((from_odd ? odd_q.size() : exp_q.size()) == 0) begin
            errors++;
            $display("FAIL %s: unexpected RX entry, scoreboard empty", name);
            return;
        end
        exp = from_odd ? odd_q.pop_front() : exp_q.pop_front();
        act = from_odd ? {o_rx_ferr, o_rx_perr, o_rx_pdata} : {rx_ferr, rx_perr, rx_pdata};
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {ferr,perr,data}=%b_%b_%h expected %b_%b_%h",
                     name, act[9], act[8], act[7:0], exp[9], exp[8], exp[7:0]);
        end
        if (from_odd) o_read_ready = 1'b1;
        else          read_ready = 1'b1;
        tick(1);
        o_read_ready = 1'b0;
        read_ready   = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        logic [14:0] act, exp;
        act = {tx_sdata, tx_pready, tx_busy, rx_valid, rx_pdata, rx_perr, rx_ferr, rx_ovf};
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {sdata,pready,busy,valid,data,perr,ferr,ovf}=%b expected %b",
                     name, act, exp);
        end
        checks++;
        if ({o_tx_sdata, o_tx_pready, o_rx_valid, o_rx_ovf} !== 4'b1100) begin
            errors++;
            $display("FAIL %s_odd: {sdata,pready,valid,ovf}=%b expected 1100", name,
                     {o_tx_sdata, o_tx_pready, o_rx_valid, o_rx_ovf});
        end
    endtask

    task automatic test_reset;
        master_reset = 1'b1;
        tick(3);
        check_reset_state("reset");
        master_reset = 1'b0;
        tick(2);
    endtask

    task automatic test_loopback;
        logic [10:0] bits;
        int          bad [11];
        loopback = 1'b1;
        bits = frame_bits(8'hA5);
        foreach (bad[k]) bad[k] = 0;
        tx_pdata = 8'hA5;
        tx_valid = 1'b1;
        exp_q.push_back({2'b00, 8'hA5});
        tick(1);
        tx_valid = 1'b0;
        checks++;
        if (tx_sdata !== 1'b1) begin
            errors++;
            $display("FAIL loopback_edge1: tx_sdata_o=%b expected 1", tx_sdata);
        end
        tick(1);
        checks++;
        if (tx_sdata !== 1'b1) begin
            errors++;
            $display("FAIL loopback_edge2: tx_sdata_o=%b expected 1 before start", tx_sdata);
        end
        tick(1);
        for (int n = 0; n < FRAME; n++) begin
            if (tx_sdata !== bits[n / CPB]) bad[n / CPB]++;
            tick(1);
        end
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (bad[k] != 0) begin
                errors++;
                $display("FAIL loopback_bit%0d: %0d cycles differed, expected level %b for all %0d",
                         k, bad[k], bits[k], CPB);
            end
        end
        checks++;
        if ({tx_sdata, tx_busy} !== 2'b10) begin
            errors++;
            $display("FAIL loopback_idle: {sdata,busy}=%b expected 10", {tx_sdata, tx_busy});
        end
        sb_pop_compare(1'b0, "loopback_a5");
        loopback = 1'b0;
    endtask

    task automatic test_parity_error;
        odd_q.push_back({2'b01, 8'h3C});
        drive_frame(1'b1, 8'h3C, 1'b1, 1'b1);
        sb_pop_compare(1'b1, "odd_parity_flipped");
        odd_q.push_back({2'b00, 8'h3C});
        drive_frame(1'b1, 8'h3C, 1'b0, 1'b1);
        sb_pop_compare(1'b1, "odd_parity_good");
        odd_q.push_back({2'b00, 8'h01});
        drive_frame(1'b1, 8'h01, 1'b0, 1'b1);
        sb_pop_compare(1'b1, "odd_parity_good_01");
    endtask

    task automatic test_framing_error;
        exp_q.push_back({2'b10, 8'h81});
        drive_frame(1'b0, 8'h81, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'h7E});
        drive_frame(1'b0, 8'h7E, 1'b0, 1'b1);
        sb_pop_compare(1'b0, "frame_err_81");
        sb_pop_compare(1'b0, "after_frame_err_7e");
    endtask

    task automatic test_false_start;
        bench_rx = 1'b0;
        tick(3);
        bench_rx = 1'b1;
        tick(20 * CPB);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL false_start: rx_pdata_valid_o=%b expected 0", rx_valid);
        end
        exp_q.push_back({2'b00, 8'h5A});
        drive_frame(1'b0, 8'h5A, 1'b0, 1'b1);
        sb_pop_compare(1'b0, "after_glitch_5a");
    endtask

    task automatic test_back_to_back;
        logic [7:0]  data [3];
        logic [10:0] bits [3];
        int          bad  [3];
        data = '{8'h11, 8'h22, 8'h33};
        loopback = 1'b1;
        for (int f = 0; f < 3; f++) begin
            bits[f] = frame_bits(data[f]);
            bad[f]  = 0;
            tx_pdata = data[f];
            tx_valid = 1'b1;
            exp_q.push_back({2'b00, data[f]});
            tick(1);
        end
        tx_valid = 1'b0;
        for (int n = 0; n < 3 * FRAME; n++) begin
            if (tx_sdata !== bits[n / FRAME][(n % FRAME) / CPB]) bad[n / FRAME]++;
            tick(1);
        end
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (bad[f] != 0) begin
                errors++;
                $display("FAIL b2b_frame%0d: %0d cycles off the gapless waveform, expected 0",
                         f, bad[f]);
            end
        end
        checks++;
        if ({tx_sdata, tx_busy} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_idle: {sdata,busy}=%b expected 10", {tx_sdata, tx_busy});
        end
        sb_pop_compare(1'b0, "b2b_11");
        sb_pop_compare(1'b0, "b2b_22");
        sb_pop_compare(1'b0, "b2b_33");
        loopback = 1'b0;
    endtask

    task automatic test_overflow_wrap;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) exp_q.push_back({2'b00, 8'(i)});
            drive_frame(1'b0, 8'(i), 1'b0, 1'b1);
            if (i == DEPTH - 1) begin
                checks++;
                if (rx_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_at_full: rx_overflow_o=%b expected 0", rx_ovf);
                end
            end
        end
        checks++;
        if (rx_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: rx_overflow_o=%b expected 1", rx_ovf);
        end
        for (int i = 0; i < DEPTH; i++) sb_pop_compare(1'b0, $sformatf("ovf_drain%0d", i));
        checks++;
        if ({rx_valid, rx_ovf} !== 2'b01) begin
            errors++;
            $display("FAIL ovf_drained: {valid,ovf}=%b expected 01", {rx_valid, rx_ovf});
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 10; i++) begin
                exp_q.push_back({2'b00, 8'(8'h80 + b * 10 + i)});
                drive_frame(1'b0, 8'(8'h80 + b * 10 + i), 1'b0, 1'b1);
            end
            for (int i = 0; i < 10; i++) sb_pop_compare(1'b0, $sformatf("wrap_b%0d_%0d", b, i));
        end
    endtask

    task automatic test_tx_full_and_reset;
        loopback = 1'b0;
        bench_rx = 1'b1;
        drive_frame(1'b0, 8'h66, 1'b0, 1'b1);
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_rx: rx_pdata_valid_o=%b expected 1", rx_valid);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            tx_pdata = 8'(8'h40 + i);
            tx_valid = 1'b1;
            tick(1);
            if (i == DEPTH - 1 || i == DEPTH) begin
                checks++;
                if (tx_pready !== (i == DEPTH - 1)) begin
                    errors++;
                    $display("FAIL pready_after_push%0d: tx_pready_o=%b expected %b",
                             i + 1, tx_pready, (i == DEPTH - 1));
                end
            end
        end
        tick(1);
        tx_valid = 1'b0;
        checks++;
        if ({tx_pready, tx_busy} !== 2'b01) begin
            errors++;
            $display("FAIL tx_full_hold: {pready,busy}=%b expected 01", {tx_pready, tx_busy});
        end
        bench_rx = 1'b0;
        tick(CPB);
        bench_rx = 1'b1;
        tick(2 * CPB);
        master_reset = 1'b1;
        exp_q.delete();
        tick(1);
        check_reset_state("reset_mid_frame");
        master_reset = 1'b0;
        tick(4 * CPB);
        exp_q.push_back({2'b00, 8'hC3});
        drive_frame(1'b0, 8'hC3, 1'b0, 1'b1);
        sb_pop_compare(1'b0, "post_reset_rx_c3");
        loopback = 1'b1;
        tx_pdata = 8'h96;
        tx_valid = 1'b1;
        exp_q.push_back({2'b00, 8'h96});
        tick(1);
        tx_valid = 1'b0;
        sb_pop_compare(1'b0, "post_reset_tx_96");
        loopback = 1'b0;
    endtask

    initial begin
        master_reset = 1'b1;
        tx_pdata     = '0;
        tx_valid     = 1'b0;
        loopback     = 1'b0;
        bench_rx     = 1'b1;
        read_ready   = 1'b0;
        o_tx_pdata   = '0;
        o_tx_valid   = 1'b0;
        odd_rx       = 1'b1;
        o_read_ready = 1'b0;

        test_reset();
        test_loopback();
        test_parity_error();
        test_framing_error();
        test_false_start();
        test_back_to_back();
        test_overflow_wrap();
        test_tx_full_and_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within 200000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
